stepper_move_ctrl: RTL



---
 rtl/stepper_move_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/stepper_move_ctrl.sv
// Stepper move controller: accepts counted moves over valid/ready, paces each
// step with a period timer, rotates the two-phase-on coil pattern and tracks
// absolute position. Coils and position hold between moves.
module stepper_move_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PER_W = 16,
  parameter int unsigned POS_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [POS_W-1:0] position,
  output logic [3:0]       d_out
);

  localparam logic [3:0] D_RESET = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_dir;
  logic [CNT_W-1:0] r_remaining;
  logic [PER_W-1:0] r_period;
  logic [PER_W-1:0] r_timer;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;
  logic [POS_W-1:0] r_position;
  logic [3:0]       r_d_out;

  logic             w_accept;
  logic [PER_W-1:0] w_period_eff;
  logic             w_step;
  logic             w_last;
  logic [3:0]       w_d_next;
  logic [POS_W-1:0] w_pos_next;

  // Handshake, period clamp and per-step next values
  assign cmd_ready    = (r_state == S_IDLE);
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_period_eff = (cmd_period == '0) ? PER_W'(1) : cmd_period;
  assign w_step       = (r_timer == '0);
  assign w_last       = (r_remaining == CNT_W'(1));
  assign w_d_next     = r_dir ? {r_d_out[2:0], r_d_out[3]} : {r_d_out[0], r_d_out[3:1]};
  assign w_pos_next   = r_dir ? (r_position + POS_W'(1)) : (r_position - POS_W'(1));

  assign busy     = r_busy;
  assign done     = r_done;
  assign aborted  = r_aborted;
  assign position = r_position;
  assign d_out    = r_d_out;

  // Move FSM: command latch, step pacing, coil rotation and position tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b0;
      r_remaining <= '0;
      r_period    <= PER_W'(1);
      r_timer     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_position  <= '0;
      r_d_out     <= D_RESET;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done    <= 1'b0;
          r_aborted <= 1'b0;
          if (w_accept) begin
            r_dir       <= cmd_dir;
            r_period    <= w_period_eff;
            r_remaining <= cmd_steps;
            r_timer     <= w_period_eff - PER_W'(1);
            if (cmd_steps == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (w_step) begin
            r_d_out     <= w_d_next;
            r_position  <= w_pos_next;
            r_remaining <= r_remaining - CNT_W'(1);
            r_timer     <= r_period - PER_W'(1);
          end else begin
            r_timer <= r_timer - PER_W'(1);
          end
          // Completing the final step wins over a coincident abort
          if (w_step && w_last) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b0;
          end else if (abort) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end
        end

        S_DONE: begin
          r_state   <= S_IDLE;
          r_done    <= 1'b0;
          r_aborted <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
